// File: rtl/alu_muldiv_seq_pkg.sv
// rtl/alu_muldiv_seq_pkg.sv - shared encodings for the multi-cycle mul/div sequencer
package alu_muldiv_seq_pkg;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

    // Ops with bit 0 set take their result from the upper register (MULHU, REMU).
    function automatic logic op_uses_hi(input op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// rtl/alu_muldiv_seq_if.sv - request/response bundle between the core and the sequencer
interface alu_muldiv_seq_if
    import alu_muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32
) ();
    logic             start;
    op_e              op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (output start, op, src_a, src_b, input busy, done, result);
    modport slave  (input start, op, src_a, src_b, output busy, done, result);
endinterface

// File: rtl/alu_muldiv_seq_muldiv_step.sv
// rtl/alu_muldiv_seq_muldiv_step.sv - one shift-add / restoring-divide step on the shared ALU
module muldiv_step
    import alu_muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             active,
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opb,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_carry,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl
);
    logic [WIDTH-1:0] sh;

    // ALU operands depend only on registered state, never on alu_res.
    always_comb begin
        sh       = {hi[WIDTH-2:0], lo[WIDTH-1]};
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_ADD;
        hi_nxt   = hi;
        lo_nxt   = lo;
        if (active) begin
            alu_b = opb;
            if (is_div) begin
                alu_a    = sh;
                alu_ctrl = ALU_SUB;
                // A set msb means the shifted remainder exceeds any divisor; the wrapped difference is exact.
                if (hi[WIDTH-1] || alu_carry) begin
                    hi_nxt = alu_res;
                    lo_nxt = {lo[WIDTH-2:0], 1'b1};
                end else begin
                    hi_nxt = sh;
                    lo_nxt = {lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                alu_a = hi;
                if (lo[0]) begin
                    hi_nxt = {alu_carry, alu_res[WIDTH-1:1]};
                    lo_nxt = {alu_res[0], lo[WIDTH-1:1]};
                end else begin
                    hi_nxt = {1'b0, hi[WIDTH-1:1]};
                    lo_nxt = {hi[0], lo[WIDTH-1:1]};
                end
            end
        end
    end
endmodule

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - 32-iteration unsigned mul/div sequencer driving the shared ALU
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_muldiv_seq_if.slave        bus,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [3:0]             alu_ctrl,
    input  logic [WIDTH-1:0]       alu_res,
    input  logic                   alu_carry
);
    state_e           state;
    op_e              op_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .active    (state == S_ITER),
        .is_div    (op_is_div(op_q)),
        .hi        (hi_q),
        .lo        (lo_q),
        .opb       (b_q),
        .alu_res   (alu_res),
        .alu_carry (alu_carry),
        .hi_nxt    (hi_nxt),
        .lo_nxt    (lo_nxt),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl)
    );

    assign bus.busy   = (state != S_IDLE);
    assign bus.done   = (state == S_DONE);
    assign bus.result = result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= OP_MUL;
            cnt      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q <= bus.op;
                        b_q  <= bus.src_b;
                        hi_q <= '0;
                        lo_q <= bus.src_a;
                        cnt  <= '0;
                        if (op_is_div(bus.op) && bus.src_b == '0) begin
                            result_q <= op_uses_hi(bus.op) ? bus.src_a : '1;
                            state    <= S_DONE;
                        end else begin
                            state <= S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    hi_q <= hi_nxt;
                    lo_q <= lo_nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        result_q <= op_uses_hi(op_q) ? hi_nxt : lo_nxt;
                        state    <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - directed table-driven bench for alu_muldiv_seq with a behavioural ALU
module tb_alu_muldiv_seq;
    import alu_muldiv_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_res;
    logic        alu_carry;
    int          total = 0;
    int          bad   = 0;

    alu_muldiv_seq_if bus ();

    alu_muldiv_seq dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .alu_res   (alu_res),
        .alu_carry (alu_carry)
    );

    always #5 clk = ~clk;

    always_comb begin
        {alu_carry, alu_res} = 33'd0;
        if (alu_ctrl == ALU_ADD)
            {alu_carry, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};
        else if (alu_ctrl == ALU_SUB)
            {alu_carry, alu_res} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
    end

    typedef struct {
        op_e         op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // lat counts cycles from the cycle start is high to the cycle done is high.
    task automatic run_op(input op_e op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy_cnt,
                          output logic [3:0] ctrl1);
        int cyc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        cyc      = 0;
        busy_cnt = 0;
        ctrl1    = 4'hx;
        res      = 32'hx;
        lat      = -1;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            bus.start = 1'b0;
            if (cyc == 1) ctrl1 = alu_ctrl;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                lat = cyc;
                res = bus.result;
                break;
            end
        end
        if (lat < 0) chk("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] res;
        logic [3:0]  ctrl1;
        int          lat;
        int          bcnt;
        logic [31:0] prev;

        tbl[0]  = '{OP_MUL,   32'd7,          32'd6,          32'h0000002A, 33};
        tbl[1]  = '{OP_MULHU, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 33};
        tbl[2]  = '{OP_MUL,   32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 33};
        tbl[3]  = '{OP_DIVU,  32'd100,        32'd7,          32'h0000000E, 33};
        tbl[4]  = '{OP_REMU,  32'd100,        32'd7,          32'h00000002, 33};
        tbl[5]  = '{OP_DIVU,  32'hFFFFFFFF,   32'h80000001,   32'h00000001, 33};
        tbl[6]  = '{OP_REMU,  32'hFFFFFFFF,   32'h80000001,   32'h7FFFFFFE, 33};
        tbl[7]  = '{OP_DIVU,  32'd5,          32'd0,          32'hFFFFFFFF, 1};
        tbl[8]  = '{OP_REMU,  32'd5,          32'd0,          32'h00000005, 1};
        tbl[9]  = '{OP_MUL,   32'h12345678,   32'h00000010,   32'h23456780, 33};
        tbl[10] = '{OP_MULHU, 32'h12345678,   32'h00000010,   32'h00000001, 33};
        tbl[11] = '{OP_REMU,  32'h80000000,   32'd3,          32'h00000002, 33};

        bus.start = 1'b0;
        bus.op    = OP_MUL;
        bus.src_a = '0;
        bus.src_b = '0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset done", {31'd0, bus.done}, 32'd0);
        chk("reset result", bus.result, 32'd0);
        chk("reset alu_a", alu_a, 32'd0);
        chk("reset alu_b", alu_b, 32'd0);
        chk("reset alu_ctrl", {28'd0, alu_ctrl}, {28'd0, ALU_ADD});
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat, bcnt, ctrl1);
            chk($sformatf("vec%0d result", i), res, tbl[i].exp);
            chk($sformatf("vec%0d latency", i), lat, tbl[i].lat);
            chk($sformatf("vec%0d busy cycles", i), bcnt, tbl[i].lat);
            if (tbl[i].lat > 1)
                chk($sformatf("vec%0d alu_ctrl", i), {28'd0, ctrl1},
                    {28'd0, op_is_div(tbl[i].op) ? ALU_SUB : ALU_ADD});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d idle after done", i), {30'd0, bus.busy, bus.done}, 32'd0);
            chk($sformatf("vec%0d result held", i), bus.result, tbl[i].exp);
        end

        // Start ignored while busy, then reset mid-iteration discards the operation.
        prev = tbl[11].exp;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.src_a = 32'd7;
        bus.src_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.src_a = 32'd1;
        bus.src_b = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ignored start done", {31'd0, bus.done}, 32'd0);
        chk("ignored start busy", {31'd0, bus.busy}, 32'd1);
        chk("ignored start result", bus.result, prev);
        chk("mid-iter alu_ctrl", {28'd0, alu_ctrl}, {28'd0, ALU_ADD});
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid reset busy", {31'd0, bus.busy}, 32'd0);
        chk("mid reset done", {31'd0, bus.done}, 32'd0);
        chk("mid reset result", bus.result, 32'd0);
        chk("mid reset alu_a", alu_a, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) bcnt++;
        end
        chk("no done after reset", bcnt, 32'd0);

        run_op(OP_MUL, 32'd3, 32'd3, res, lat, bcnt, ctrl1);
        chk("post reset mul result", res, 32'd9);
        chk("post reset mul latency", lat, 32'd33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
